lbus_arbiter: RTL

- Shares one internal register bus (req/rw/addr/wdata → rdata/ack/err) between N_REQ requesters, e.g. the AXI-Lite register bridge plus a debug/JTAG master.
- Round-robin arbitration. One transaction in flight at a time.
- Sits between the bus-protocol bridges and the register decode fabric. Optionally guarantees completion via a no-ack watchdog.

---
 rtl/lbus_pkg.sv | 22 ++
 rtl/rr_pick.sv | 30 +++
 rtl/lbus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lbus_pkg.sv
// Shared types and constants for the internal register bus arbiter family.
package lbus_pkg;

   localparam int LBUS_AW_MSB = 31;
   localparam int LBUS_AW_LSB = 2;
   localparam int LBUS_AW     = LBUS_AW_MSB - LBUS_AW_LSB + 1;

   localparam logic [31:0] LBUS_TO_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } lbus_state_e;

   typedef struct packed {
      logic                           rw;
      logic [LBUS_AW_MSB:LBUS_AW_LSB] addr;
      logic [31:0]                    wdata;
   } lbus_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin chooser: first set request after 'last', wrapping.
module rr_pick #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int off = N; off >= 1; off--) begin
         cand = (int'(last) + off) % N;
         if (req[cand]) begin
            idx = IW'(cand);
            any = 1'b1;
         end
      end
      onehot = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/lbus_arbiter.sv
// Round-robin arbiter sharing one register bus among N_REQ requesters.
// Optional no-ack watchdog enabled by defining LBUS_ARB_TIMEOUT_EN.
module lbus_arbiter
   import lbus_pkg::*;
#(
   parameter int          N_REQ    = 2,
   parameter int          TO_CYC   = 1024,
   parameter logic [31:0] TO_RDATA = LBUS_TO_RDATA
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         m_req,
   input  logic [N_REQ-1:0]         m_rw,
   input  logic [N_REQ*LBUS_AW-1:0] m_addr,
   input  logic [N_REQ*32-1:0]      m_wdata,
   output logic [31:0]              m_rdata,
   output logic [N_REQ-1:0]         m_ack,
   output logic [N_REQ-1:0]         m_err,
   output logic                     lbus_req,
   output logic                     lbus_rw,
   output logic [LBUS_AW-1:0]       lbus_addr,
   output logic [31:0]              lbus_wdata,
   input  logic [31:0]              lbus_rdata,
   input  logic                     lbus_ack,
   input  logic                     lbus_err,
`ifdef LBUS_ARB_TIMEOUT_EN
   output logic                     to_flag,
`endif
   output logic [N_REQ-1:0]         grant
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   lbus_state_e      state_reg;
   logic [IW-1:0]    last_grant_reg;
   logic [N_REQ-1:0] grant_reg;
   logic             lbus_req_reg;
   lbus_req_t        cap_reg;

   lbus_req_t        req_arr [N_REQ];
   logic [N_REQ-1:0] pick_onehot;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;
   logic             to_hit;
   logic             done;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_arr[gi].rw    = m_rw[gi];
      assign req_arr[gi].addr  = m_addr[gi*LBUS_AW +: LBUS_AW];
      assign req_arr[gi].wdata = m_wdata[gi*32 +: 32];
   end

   rr_pick #(.N(N_REQ)) u_pick (
      .req    (m_req),
      .last   (last_grant_reg),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

`ifdef LBUS_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYC + 1);

   logic [TO_W-1:0] to_cnt_reg;
   logic            to_flag_reg;

   assign to_hit = (state_reg == BUSY) && !lbus_ack &&
                   (to_cnt_reg == TO_W'(TO_CYC - 1));

   // Count stays at zero outside BUSY, so it is clear on every BUSY entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_reg  <= '0;
         to_flag_reg <= 1'b0;
      end else begin
         if (state_reg != BUSY)
            to_cnt_reg <= '0;
         else if (!lbus_ack)
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
         if (to_hit)
            to_flag_reg <= 1'b1;
      end
   end

   assign to_flag = to_flag_reg;
`else
   assign to_hit = 1'b0;
`endif

   assign done = (state_reg == BUSY) && (lbus_ack || to_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= IW'(N_REQ - 1);
         grant_reg      <= '0;
         lbus_req_reg   <= 1'b0;
         cap_reg        <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  state_reg      <= BUSY;
                  lbus_req_reg   <= 1'b1;
                  cap_reg        <= req_arr[pick_idx];
                  grant_reg      <= pick_onehot;
                  last_grant_reg <= pick_idx;
               end
            end
            BUSY: begin
               if (done) begin
                  state_reg    <= GAP;
                  lbus_req_reg <= 1'b0;
                  grant_reg    <= '0;
               end
            end
            GAP:     state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Completion is routed combinationally so the requester sees ack in the same cycle.
   always_comb begin
      m_ack   = '0;
      m_err   = '0;
      m_rdata = '0;
      if (state_reg == BUSY) begin
         if (lbus_ack) begin
            m_ack   = grant_reg;
            m_err   = lbus_err ? grant_reg : '0;
            m_rdata = lbus_rdata;
         end else if (to_hit) begin
            m_ack   = grant_reg;
            m_err   = grant_reg;
            m_rdata = TO_RDATA;
         end
      end
   end

   assign lbus_req   = lbus_req_reg;
   assign lbus_rw    = cap_reg.rw;
   assign lbus_addr  = cap_reg.addr;
   assign lbus_wdata = cap_reg.wdata;
   assign grant      = grant_reg;

endmodule
